// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: four-state (IDLE/READ/EXEC/WB) execute sequencer for the shared ALU.
// Optional macro ALU_IMM_SIGN_EXT_EN: sign-extend the immediate B operand instead of zero-extending it.
module alu_exec_ctrl #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int IMM_W  = 8,
    parameter int FLAG_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [7:0]        issue_op,
    input  logic [REG_AW-1:0] issue_rdest,
    input  logic [REG_AW-1:0] issue_rsrc,
    input  logic [IMM_W-1:0]  issue_imm,
    output logic [REG_AW-1:0] rf_raddr_a,
    output logic [REG_AW-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [7:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic [FLAG_W-1:0] psr,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hB;

    state_t            state_r;
    logic [7:0]        op_r;
    logic [7:0]        alu_op_r;
    logic [IMM_W-1:0]  imm_r;
    logic [REG_AW-1:0] raddr_a_r;
    logic [REG_AW-1:0] raddr_b_r;
    logic [REG_AW-1:0] waddr_r;
    logic [DATA_W-1:0] alu_a_r;
    logic [DATA_W-1:0] alu_b_r;
    logic [DATA_W-1:0] wdata_r;
    logic [FLAG_W-1:0] flags_r;
    logic [FLAG_W-1:0] psr_r;
    logic              rf_we_r;
    logic              done_r;
    logic              busy_r;
    logic              ready_r;

    logic              reg_form_s;
    logic [7:0]        eff_op_s;
    logic [DATA_W-1:0] opnd_b_s;
    logic [DATA_W-1:0] alu_a_s;
    logic [DATA_W-1:0] alu_b_s;

    function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm);
`ifdef ALU_IMM_SIGN_EXT_EN
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
`else
        return {{(DATA_W-IMM_W){1'b0}}, imm};
`endif
    endfunction

    // Flag bits {N,Z,F,L,C}: arithmetic owns C/F, compare owns N/Z/L.
    function automatic logic [FLAG_W-1:0] psr_mask(input logic [3:0] nib);
        logic [FLAG_W-1:0] mask;
        case (nib)
            OP_ADD, OP_SUB: mask = 5'b00101;
            OP_CMP:         mask = 5'b11010;
            default:        mask = 5'b00000;
        endcase
        return mask;
    endfunction

    function automatic logic [FLAG_W-1:0] psr_merge(input logic [FLAG_W-1:0] cur,
                                                    input logic [FLAG_W-1:0] flags,
                                                    input logic [3:0]        nib);
        logic [FLAG_W-1:0] mask;
        mask = psr_mask(nib);
        return (cur & ~mask) | (flags & mask);
    endfunction

    // Decode the latched opcode into the effective ALU op and the B operand source.
    always_comb begin
        reg_form_s = (op_r[7:4] == 4'h0);
        if (reg_form_s) begin
            eff_op_s = op_r;
            opnd_b_s = rf_rdata_b;
        end else begin
            eff_op_s = {4'h0, op_r[7:4]};
            opnd_b_s = ext_imm(imm_r);
        end
    end

    // Read data only arrives in EXEC, so the operands pass through then and are held afterwards.
    always_comb begin
        if (state_r == ST_EXEC) begin
            alu_a_s = rf_rdata_a;
            alu_b_s = opnd_b_s;
        end else begin
            alu_a_s = alu_a_r;
            alu_b_s = alu_b_r;
        end
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            op_r      <= 8'h00;
            alu_op_r  <= 8'h00;
            imm_r     <= '0;
            raddr_a_r <= '0;
            raddr_b_r <= '0;
            waddr_r   <= '0;
            alu_a_r   <= '0;
            alu_b_r   <= '0;
            wdata_r   <= '0;
            flags_r   <= '0;
            psr_r     <= '0;
            rf_we_r   <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rf_we_r <= 1'b0;
                    done_r  <= 1'b0;
                    if (issue_valid) begin
                        op_r      <= issue_op;
                        imm_r     <= issue_imm;
                        raddr_a_r <= issue_rdest;
                        raddr_b_r <= issue_rsrc;
                        ready_r   <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_READ;
                    end
                end
                ST_READ: begin
                    alu_op_r <= eff_op_s;
                    state_r  <= ST_EXEC;
                end
                ST_EXEC: begin
                    alu_a_r <= alu_a_s;
                    alu_b_r <= alu_b_s;
                    wdata_r <= alu_result;
                    flags_r <= alu_flags;
                    waddr_r <= raddr_a_r;
                    rf_we_r <= (eff_op_s[3:0] != OP_CMP);
                    done_r  <= 1'b1;
                    state_r <= ST_WB;
                end
                ST_WB: begin
                    rf_we_r <= 1'b0;
                    done_r  <= 1'b0;
                    psr_r   <= psr_merge(psr_r, flags_r, eff_op_s[3:0]);
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    rf_we_r <= 1'b0;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign issue_ready = ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign rf_raddr_a  = raddr_a_r;
    assign rf_raddr_b  = raddr_b_r;
    assign rf_we       = rf_we_r;
    assign rf_waddr    = waddr_r;
    assign rf_wdata    = wdata_r;
    assign alu_a       = alu_a_s;
    assign alu_b       = alu_b_s;
    assign alu_op      = alu_op_r;
    assign psr         = psr_r;

endmodule
